// File: rtl/crc32_multi_hash.sv
// Multi-row CRC-32 key hasher: NUM_HASH seeded reflected CRC-32 rows, 2-stage elastic pipeline.
// Stage 1 folds the upper half of the key bytes, stage 2 the rest plus the final inversion.
module crc32_multi_hash #(
  parameter int                       DATA_W   = 64,
  parameter int                       NUM_HASH = 3,
  parameter int                       IDX_W    = 16,
  parameter int                       TAG_W    = 8,
  parameter logic [NUM_HASH*32-1:0]   SEEDS    = {32'h9E3779B9, 32'h5A5A5A5A, 32'hFFFFFFFF}
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_HASH*32-1:0]    out_crc,
  output logic [NUM_HASH*IDX_W-1:0] out_idx,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_count
);

  localparam int NB     = DATA_W / 8;
  localparam int NB1    = NB / 2;
  localparam int KEY2_W = (NB - NB1) * 8;

  // One byte of the LSB-first CRC-32 (reflected polynomial 0xEDB88320).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  logic                      r_s1_valid;
  logic [KEY2_W-1:0]         r_s1_key;
  logic [TAG_W-1:0]          r_s1_tag;
  logic [NUM_HASH*32-1:0]    r_s1_crc;
  logic                      r_out_valid;
  logic [NUM_HASH*32-1:0]    r_out_crc;
  logic [TAG_W-1:0]          r_out_tag;
  logic [31:0]               r_out_count;

  logic [NUM_HASH*32-1:0]    w_s1_crc;
  logic [NUM_HASH*32-1:0]    w_s2_crc;
  logic                      w_s1_load;
  logic                      w_s2_load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HASH; gi++) begin : g_row
      logic [31:0] w_part;
      logic [31:0] w_full;

      always_comb begin
        w_part = SEEDS[32*gi +: 32];
        for (int j = 0; j < NB1; j++) begin
          w_part = crc_byte(w_part, in_data[DATA_W-1-8*j -: 8]);
        end
      end

      // Only the lower bytes travel to stage 2; the upper ones are already folded in.
      always_comb begin
        w_full = r_s1_crc[32*gi +: 32];
        for (int j = 0; j < NB - NB1; j++) begin
          w_full = crc_byte(w_full, r_s1_key[KEY2_W-1-8*j -: 8]);
        end
      end

      assign w_s1_crc[32*gi +: 32]     = w_part;
      assign w_s2_crc[32*gi +: 32]     = ~w_full;
      assign out_idx[IDX_W*gi +: IDX_W] = r_out_crc[32*gi +: IDX_W];
    end
  endgenerate

  assign w_s2_load = ~r_out_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = ~r_s1_valid | ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_key    <= '0;
      r_s1_tag    <= '0;
      r_s1_crc    <= '0;
      r_out_valid <= 1'b0;
      r_out_crc   <= '0;
      r_out_tag   <= '0;
      r_out_count <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_key <= in_data[KEY2_W-1:0];
          r_s1_tag <= in_tag;
          r_s1_crc <= w_s1_crc;
        end
      end
      // Output registers only change on a real load so stalled results hold still.
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_crc <= w_s2_crc;
          r_out_tag <= r_s1_tag;
        end
      end
      if (r_out_valid && out_ready) begin
        r_out_count <= r_out_count + 32'd1;
      end
    end
  end

  assign out_crc   = r_out_crc;
  assign out_tag   = r_out_tag;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_crc32_multi_hash.sv
// Scoreboard bench for crc32_multi_hash: bit-serial reference model, directed and random flow control.
module tb_crc32_multi_hash;

  localparam logic [95:0] SEEDS_TB = {32'h9E3779B9, 32'h5A5A5A5A, 32'hFFFFFFFF};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_tag = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] out_crc;
  logic [47:0] out_idx;
  logic [7:0]  out_tag;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_count;

  // Known-vector instances
  logic        kv_valid = 1'b0;
  logic [71:0] kv72_data = 72'h313233343536373839;
  logic [31:0] kv32_data = 32'h0;
  logic        kv72_in_ready, kv72_out_valid, kv32_in_ready, kv32_out_valid;
  logic [31:0] kv72_crc, kv32_crc, kv72_count, kv32_count;
  logic [15:0] kv72_idx, kv32_idx;
  logic [7:0]  kv72_tag, kv32_tag;

  always #5 clk = ~clk;

  crc32_multi_hash #(.DATA_W(64), .NUM_HASH(3), .IDX_W(16), .TAG_W(8), .SEEDS(SEEDS_TB)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(in_ready), .out_crc(out_crc), .out_idx(out_idx), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count));

  crc32_multi_hash #(.DATA_W(72), .NUM_HASH(1), .IDX_W(16), .TAG_W(8), .SEEDS(32'hFFFFFFFF)) u_kv72 (
    .clk(clk), .reset_n(reset_n), .in_data(kv72_data), .in_tag(8'hA5), .in_valid(kv_valid),
    .in_ready(kv72_in_ready), .out_crc(kv72_crc), .out_idx(kv72_idx), .out_tag(kv72_tag),
    .out_valid(kv72_out_valid), .out_ready(1'b1), .out_count(kv72_count));

  crc32_multi_hash #(.DATA_W(32), .NUM_HASH(1), .IDX_W(16), .TAG_W(8), .SEEDS(32'hFFFFFFFF)) u_kv32 (
    .clk(clk), .reset_n(reset_n), .in_data(kv32_data), .in_tag(8'h3C), .in_valid(kv_valid),
    .in_ready(kv32_in_ready), .out_crc(kv32_crc), .out_idx(kv32_idx), .out_tag(kv32_tag),
    .out_valid(kv32_out_valid), .out_ready(1'b1), .out_count(kv32_count));

  typedef struct {
    logic [95:0] crc;
    logic [47:0] idx;
    logic [7:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  logic [31:0] exp_count = '0;
  bit          stall_prev = 1'b0;
  logic [95:0] hold_crc;
  logic [47:0] hold_idx;
  logic [7:0]  hold_tag;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-at-a-time reference: bytes MSB-first, bits LSB-first, final inversion.
  function automatic logic [31:0] ref_crc(input logic [127:0] key, input int nbytes, input logic [31:0] seed);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = seed;
    for (int i = 0; i < nbytes; i++) begin
      b = key[8*(nbytes-1-i) +: 8];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // Looks at the handshakes about to happen at the next rising edge.
  task automatic monitor();
    exp_t e;
    logic [31:0] c;
    if (stall_prev) begin
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_crc", out_crc, hold_crc);
      check_eq("stall_idx", out_idx, hold_idx);
      check_eq("stall_tag", out_tag, hold_tag);
    end
    stall_prev = out_valid && !out_ready;
    hold_crc = out_crc;
    hold_idx = out_idx;
    hold_tag = out_tag;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("out_crc", out_crc, e.crc);
        check_eq("out_idx", out_idx, e.idx);
        check_eq("out_tag", out_tag, e.tag);
        $display("out #%0d tag=%02h crc=%024h", exp_count, out_tag, out_crc);
      end
      exp_count = exp_count + 32'd1;
    end
    if (in_valid && in_ready) begin
      for (int r = 0; r < 3; r++) begin
        c = ref_crc({64'd0, in_data}, 8, SEEDS_TB[32*r +: 32]);
        e.crc[32*r +: 32] = c;
        e.idx[16*r +: 16] = c[15:0];
      end
      e.tag = in_tag;
      sb.push_back(e);
      n_acc++;
    end
  endtask

  task automatic step(input bit v, input logic [63:0] d, input logic [7:0] t, input bit ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    #1;
    monitor();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int acc0;

    // Reset state
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_crc", out_crc, 96'd0);
    check_eq("rst_out_idx", out_idx, 48'd0);
    check_eq("rst_out_tag", out_tag, 8'd0);
    check_eq("rst_out_count", out_count, 32'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Known vectors on the side instances
    @(negedge clk);
    kv_valid = 1'b1;
    @(negedge clk);
    kv_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3 && !found; c++) begin
      @(negedge clk);
      #1;
      if (kv72_out_valid && kv32_out_valid) found = 1'b1;
    end
    check_eq("kv_latency", found, 1'b1);
    check_eq("kv72_crc", kv72_crc, 32'hCBF43926);
    check_eq("kv72_idx", kv72_idx, 16'h3926);
    check_eq("kv72_tag", kv72_tag, 8'hA5);
    check_eq("kv32_crc", kv32_crc, 32'h2144DF1C);

    // Back-to-back keys with out_ready held high
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, {$urandom, $urandom}, 8'($urandom), 1'b1);
      check_eq("in_ready_b2b", in_ready, 1'b1);
    end
    repeat (3) step(1'b0, 64'd0, 8'd0, 1'b1);
    check_eq("count_1000", out_count, 32'd1000);
    check_eq("sb_drain_a", sb.size(), 0);

    // Stalled output: exactly two keys accepted
    acc0 = n_acc;
    repeat (5) step(1'b1, {$urandom, $urandom}, 8'($urandom), 1'b0);
    check_eq("stall_accepts", n_acc - acc0, 2);
    check_eq("stall_in_ready", in_ready, 1'b0);
    repeat (4) step(1'b0, 64'd0, 8'd0, 1'b1);
    check_eq("sb_drain_b", sb.size(), 0);

    // Random valid / ready
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)));
      check_eq("occupancy", sb.size() <= 2, 1'b1);
    end
    repeat (4) step(1'b0, 64'd0, 8'd0, 1'b1);
    check_eq("sb_drain_c", sb.size(), 0);
    check_eq("count_c", out_count, exp_count);

    // Reset with two keys in flight
    step(1'b1, 64'h0123456789ABCDEF, 8'h11, 1'b0);
    step(1'b1, 64'hFEDCBA9876543210, 8'h22, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_count", out_count, 32'd0);
    check_eq("mid_rst_ready", in_ready, 1'b1);
    sb.delete();
    stall_prev = 1'b0;
    exp_count  = '0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 64'd0, 8'd0, 1'b1);
      check_eq("post_rst_valid", out_valid, 1'b0);
    end
    step(1'b1, 64'h00000000DEADBEEF, 8'h5E, 1'b1);
    repeat (3) step(1'b0, 64'd0, 8'd0, 1'b1);
    check_eq("post_rst_count", out_count, 32'd1);

    // Counter wrap
    @(negedge clk);
    #2 force u_dut.r_out_count = 32'hFFFFFFFF;
    #1 release u_dut.r_out_count;
    #1 check_eq("count_preload", out_count, 32'hFFFFFFFF);
    exp_count = 32'hFFFFFFFF;
    step(1'b1, 64'h1122334455667788, 8'h77, 1'b1);
    repeat (3) step(1'b0, 64'd0, 8'd0, 1'b1);
    check_eq("count_wrap", out_count, 32'd0);
    check_eq("count_wrap_model", out_count, exp_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
